// File: rtl/food_spawner.sv
// -----------------------------------------------------------------------------
// food_spawner
//
// Picks a free grid cell for the Snake food. On a spawn request it draws
// random candidates from the LFSR stream. Each candidate is checked against
// the snake body store through a query port with one cycle of latency. After
// MAX_TRIES rejected candidates it falls back to a linear scan of the grid.
// The scan starts just past the last rejected candidate and ends at the first
// free cell, or after every cell has been visited (grid full).
//
// Ports
//   I_clk         clock
//   I_rst_n       synchronous active-low reset
//   rand_num      10-bit pseudo-random sample (only [5:0] / [4:0] are used)
//   spawn_req     one-cycle request, accepted only when idle
//   chk_en        occupancy query strobe (one cycle)
//   chk_x/chk_y   queried cell; holds its value between queries
//   chk_occupied  query answer, valid the cycle after chk_en
//   food_x/food_y placed food cell; holds until the next placement
//   food_valid    food_x/food_y hold a placed position
//   spawn_done    one-cycle pulse on placement
//   busy          request in progress
//   grid_full     last request found no free cell
// -----------------------------------------------------------------------------
module food_spawner #(
   parameter int         GRID_W    = 40,
   parameter int         GRID_H    = 30,
   parameter logic [7:0] MAX_TRIES = 8'd16
) (
   input  logic       I_clk,
   input  logic       I_rst_n,
   input  logic [9:0] rand_num,
   input  logic       spawn_req,
   output logic       chk_en,
   output logic [5:0] chk_x,
   output logic [4:0] chk_y,
   input  logic       chk_occupied,
   output logic [5:0] food_x,
   output logic [4:0] food_y,
   output logic       food_valid,
   output logic       spawn_done,
   output logic       busy,
   output logic       grid_full
);

   localparam logic [6:0]  X_SPAN = 7'(GRID_W);
   localparam logic [5:0]  Y_SPAN = 6'(GRID_H);
   localparam logic [5:0]  X_LAST = 6'(GRID_W - 1);
   localparam logic [4:0]  Y_LAST = 5'(GRID_H - 1);
   // For a 64x32 grid this truncates to 0. The 11-bit count also wraps to 0
   // on the 2048th rejection, so the compare still fires at the right moment.
   localparam logic [10:0] CELLS  = 11'(GRID_W * GRID_H);

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE_X,
      SAMPLE_Y,
      CHECK,
      WAIT,
      SCAN_CHECK,
      SCAN_WAIT
   } state_t;

   state_t      r_state;
   logic [5:0]  r_cand_x;      // random candidate, then scan pointer
   logic [4:0]  r_cand_y;
   logic [7:0]  r_tries;
   logic [10:0] r_scan_cnt;
   logic        r_chk_en;
   logic [5:0]  r_chk_x;
   logic [4:0]  r_chk_y;
   logic [5:0]  r_food_x;
   logic [4:0]  r_food_y;
   logic        r_food_valid;
   logic        r_spawn_done;
   logic        r_busy;
   logic        r_grid_full;

   logic [6:0]  w_rx_wide;
   logic [5:0]  w_ry_wide;
   logic [5:0]  w_samp_x;
   logic [4:0]  w_samp_y;
   logic [5:0]  w_next_x;
   logic [4:0]  w_next_y;
   logic [7:0]  w_tries_next;
   logic [10:0] w_scan_next;
   logic        w_unused;

   // The upper random bits are not needed for a 64x32 or smaller grid.
   assign w_unused = ^rand_num[9:6];

   // A single conditional subtraction suffices: 63 - 32 < 32 and 31 - 16 < 16.
   assign w_rx_wide = {1'b0, rand_num[5:0]};
   assign w_ry_wide = {1'b0, rand_num[4:0]};
   assign w_samp_x  = (w_rx_wide >= X_SPAN) ? 6'(w_rx_wide - X_SPAN) : rand_num[5:0];
   assign w_samp_y  = (w_ry_wide >= Y_SPAN) ? 5'(w_ry_wide - Y_SPAN) : rand_num[4:0];

   // Row-major walk over the grid, wrapping from the last cell back to (0,0).
   always_comb begin
      w_next_x = r_cand_x + 6'd1;
      w_next_y = r_cand_y;
      if (r_cand_x == X_LAST) begin
         w_next_x = '0;
         w_next_y = (r_cand_y == Y_LAST) ? 5'd0 : r_cand_y + 5'd1;
      end
   end

   assign w_tries_next = r_tries + 8'd1;
   assign w_scan_next  = r_scan_cnt + 11'd1;

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         r_state      <= IDLE;
         r_cand_x     <= '0;
         r_cand_y     <= '0;
         r_tries      <= '0;
         r_scan_cnt   <= '0;
         r_chk_en     <= 1'b0;
         r_chk_x      <= '0;
         r_chk_y      <= '0;
         r_food_x     <= '0;
         r_food_y     <= '0;
         r_food_valid <= 1'b0;
         r_spawn_done <= 1'b0;
         r_busy       <= 1'b0;
         r_grid_full  <= 1'b0;
      end else begin
         r_spawn_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (spawn_req) begin
                  r_food_valid <= 1'b0;
                  r_grid_full  <= 1'b0;
                  r_busy       <= 1'b1;
                  r_tries      <= '0;
                  r_state      <= SAMPLE_X;
               end
            end
            SAMPLE_X: begin
               r_cand_x <= w_samp_x;
               r_state  <= SAMPLE_Y;
            end
            SAMPLE_Y: begin
               // Issue the query on the same edge y is captured so chk_en
               // is high for the whole CHECK cycle.
               r_cand_y <= w_samp_y;
               r_chk_en <= 1'b1;
               r_chk_x  <= r_cand_x;
               r_chk_y  <= w_samp_y;
               r_state  <= CHECK;
            end
            CHECK: begin
               r_chk_en <= 1'b0;
               r_state  <= WAIT;
            end
            WAIT: begin
               if (!chk_occupied) begin
                  r_food_x     <= r_cand_x;
                  r_food_y     <= r_cand_y;
                  r_food_valid <= 1'b1;
                  r_spawn_done <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= IDLE;
               end else begin
                  r_tries <= w_tries_next;
                  if (w_tries_next == MAX_TRIES) begin
                     r_cand_x   <= w_next_x;
                     r_cand_y   <= w_next_y;
                     r_scan_cnt <= '0;
                     r_chk_en   <= 1'b1;
                     r_chk_x    <= w_next_x;
                     r_chk_y    <= w_next_y;
                     r_state    <= SCAN_CHECK;
                  end else begin
                     r_state <= SAMPLE_X;
                  end
               end
            end
            SCAN_CHECK: begin
               r_chk_en <= 1'b0;
               r_state  <= SCAN_WAIT;
            end
            SCAN_WAIT: begin
               if (!chk_occupied) begin
                  r_food_x     <= r_cand_x;
                  r_food_y     <= r_cand_y;
                  r_food_valid <= 1'b1;
                  r_spawn_done <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= IDLE;
               end else begin
                  r_scan_cnt <= w_scan_next;
                  if (w_scan_next == CELLS) begin
                     r_grid_full <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= IDLE;
                  end else begin
                     r_cand_x <= w_next_x;
                     r_cand_y <= w_next_y;
                     r_chk_en <= 1'b1;
                     r_chk_x  <= w_next_x;
                     r_chk_y  <= w_next_y;
                     r_state  <= SCAN_CHECK;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign chk_en     = r_chk_en;
   assign chk_x      = r_chk_x;
   assign chk_y      = r_chk_y;
   assign food_x     = r_food_x;
   assign food_y     = r_food_y;
   assign food_valid = r_food_valid;
   assign spawn_done = r_spawn_done;
   assign busy       = r_busy;
   assign grid_full  = r_grid_full;

endmodule
